// File: rtl/xor_parity_pkg.sv
// Shared types and elaboration helpers for the xor_parity_accum parity generator/checker.
package xor_parity_pkg;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_e;

   function automatic int nlanes(input int width, input int lane);
      return width / lane;
   endfunction

   function automatic bit lane_cfg_ok(input int width, input int lane);
      return (lane > 0) && (width >= lane) && ((width % lane) == 0);
   endfunction

   function automatic logic xor_reduce8(input logic [7:0] v);
      return ^v;
   endfunction

endpackage

// File: rtl/xor_parity_accum_tree.sv
// Combinational XOR reduction of an N-bit vector to a single parity bit.
module xor_lane_tree #(
   parameter int N = 8
) (
   input  logic [N-1:0] a,
   output logic         y
);

   assign y = ^a;

endmodule

// File: rtl/xor_parity_accum.sv
// Registered per-lane / whole-word parity generator with packet parity accumulation
// and an optional lane-parity checker with sticky error.
module xor_parity_accum
   import xor_parity_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int LANE  = 8,
   parameter int ODD   = 0
) (
   input  logic                            CK,
   input  logic                            RSTN,
   input  logic                            CE,
   input  logic                            VI,
   input  logic                            SOP,
   input  logic                            EOP,
   input  logic [WIDTH-1:0]                D,
   input  logic                            CHKEN,
   input  logic [nlanes(WIDTH, LANE)-1:0]  PCHK,
   input  logic                            CLR,
   output logic                            VO,
   output logic [nlanes(WIDTH, LANE)-1:0]  ZL,
   output logic                            Z0,
   output logic [nlanes(WIDTH, LANE)-1:0]  LERR,
   output logic                            PKTV,
   output logic                            PKTZ,
   output logic                            SERR,
   output logic                            ERR
);

   localparam int   NL    = nlanes(WIDTH, LANE);
   localparam logic ODD_B = (ODD != 0);

   if (!lane_cfg_ok(WIDTH, LANE)) begin : g_cfg_err
      $error("xor_parity_accum: WIDTH must be a non-zero multiple of LANE");
   end

   logic [NL-1:0] lane_x_s;
   logic          word_x_s;
   logic [NL-1:0] lane_par_s;
   logic          word_par_s;

   for (genvar gi = 0; gi < NL; gi++) begin : g_lane
      xor_lane_tree #(.N(LANE)) u_lane (
         .a (D[gi*LANE +: LANE]),
         .y (lane_x_s[gi])
      );
   end

   // Whole-word parity is folded from the lane results rather than the raw bus.
   xor_lane_tree #(.N(NL)) u_word (
      .a (lane_x_s),
      .y (word_x_s)
   );

   assign lane_par_s = lane_x_s ^ {NL{ODD_B}};
   assign word_par_s = word_x_s ^ ODD_B;

   state_e        state_q, state_d;
   logic          acc_q, acc_d;
   logic          vo_q, vo_d;
   logic [NL-1:0] zl_q, zl_d;
   logic          z0_q, z0_d;
   logic [NL-1:0] lerr_q, lerr_d;
   logic          pktv_q, pktv_d;
   logic          pktz_q, pktz_d;
   logic          serr_q, serr_d;
   logic          err_q, err_d;

   // Next-state: beat outputs, packet FSM and sticky error; CE=0 holds everything.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      vo_d    = vo_q;
      zl_d    = zl_q;
      z0_d    = z0_q;
      lerr_d  = lerr_q;
      pktv_d  = pktv_q;
      pktz_d  = pktz_q;
      serr_d  = serr_q;
      err_d   = err_q;
      if (CE) begin
         vo_d   = VI;
         lerr_d = {NL{1'b0}};
         pktv_d = 1'b0;
         serr_d = 1'b0;
         if (VI) begin
            zl_d = lane_par_s;
            z0_d = word_par_s;
            if (CHKEN) begin
               lerr_d = lane_par_s ^ PCHK;
            end else begin
               lerr_d = {NL{1'b0}};
            end
            case (state_q)
               IDLE: begin
                  if (SOP && EOP) begin
                     pktv_d = 1'b1;
                     pktz_d = word_par_s;
                  end else if (SOP) begin
                     acc_d   = word_x_s;
                     state_d = ACTIVE;
                  end else begin
                     serr_d = 1'b1;
                  end
               end
               ACTIVE: begin
                  // A SOP inside a packet is a framing error that restarts the packet.
                  if (SOP && EOP) begin
                     serr_d  = 1'b1;
                     pktv_d  = 1'b1;
                     pktz_d  = word_par_s;
                     state_d = IDLE;
                  end else if (SOP) begin
                     serr_d = 1'b1;
                     acc_d  = word_x_s;
                  end else if (EOP) begin
                     pktv_d  = 1'b1;
                     pktz_d  = acc_q ^ word_par_s;
                     state_d = IDLE;
                  end else begin
                     acc_d = acc_q ^ word_x_s;
                  end
               end
               default: begin
                  state_d = IDLE;
               end
            endcase
         end else begin
            zl_d = zl_q;
            z0_d = z0_q;
         end
         if ((|lerr_d) || serr_d) begin
            err_d = 1'b1;
         end else if (CLR) begin
            err_d = 1'b0;
         end else begin
            err_d = err_q;
         end
      end else begin
         state_d = state_q;
      end
   end

   // State and output registers.
   always_ff @(posedge CK or negedge RSTN) begin
      if (!RSTN) begin
         state_q <= IDLE;
         acc_q   <= 1'b0;
         vo_q    <= 1'b0;
         zl_q    <= {NL{1'b0}};
         z0_q    <= 1'b0;
         lerr_q  <= {NL{1'b0}};
         pktv_q  <= 1'b0;
         pktz_q  <= 1'b0;
         serr_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         vo_q    <= vo_d;
         zl_q    <= zl_d;
         z0_q    <= z0_d;
         lerr_q  <= lerr_d;
         pktv_q  <= pktv_d;
         pktz_q  <= pktz_d;
         serr_q  <= serr_d;
         err_q   <= err_d;
      end
   end

   assign VO   = vo_q;
   assign ZL   = zl_q;
   assign Z0   = z0_q;
   assign LERR = lerr_q;
   assign PKTV = pktv_q;
   assign PKTZ = pktz_q;
   assign SERR = serr_q;
   assign ERR  = err_q;

endmodule

// File: tb/tb_xor_parity_accum.sv
// Self-checking bench: an even-parity and an odd-parity instance share stimulus and
// are compared against a packet-level parity model.
module tb_xor_parity_accum;

   logic        CK = 1'b0;
   logic        RSTN, CE, VI, SOP, EOP, CHKEN, CLR;
   logic [31:0] D;
   logic [3:0]  PCHK;

   logic        vo [2], z0 [2], pktv [2], pktz [2], serr [2], err [2];
   logic [3:0]  zl [2], lerr [2];

   int n_tests = 0;
   int n_fail  = 0;

   // Model state: packet membership and running ones-count since SOP.
   bit          m_in_pkt;
   int          m_ones;
   logic        m_vo [2], m_z0 [2], m_pktv [2], m_pktz [2], m_serr [2], m_err [2];
   logic [3:0]  m_zl [2], m_lerr [2];

   always #5 CK = ~CK;

   xor_parity_accum #(.WIDTH(32), .LANE(8), .ODD(0)) u_even (
      .CK(CK), .RSTN(RSTN), .CE(CE), .VI(VI), .SOP(SOP), .EOP(EOP), .D(D),
      .CHKEN(CHKEN), .PCHK(PCHK), .CLR(CLR), .VO(vo[0]), .ZL(zl[0]), .Z0(z0[0]),
      .LERR(lerr[0]), .PKTV(pktv[0]), .PKTZ(pktz[0]), .SERR(serr[0]), .ERR(err[0])
   );

   xor_parity_accum #(.WIDTH(32), .LANE(8), .ODD(1)) u_odd (
      .CK(CK), .RSTN(RSTN), .CE(CE), .VI(VI), .SOP(SOP), .EOP(EOP), .D(D),
      .CHKEN(CHKEN), .PCHK(PCHK), .CLR(CLR), .VO(vo[1]), .ZL(zl[1]), .Z0(z0[1]),
      .LERR(lerr[1]), .PKTV(pktv[1]), .PKTZ(pktz[1]), .SERR(serr[1]), .ERR(err[1])
   );

   function automatic logic [13:0] obs(input int k);
      return {vo[k], z0[k], pktv[k], pktz[k], serr[k], err[k], zl[k], lerr[k]};
   endfunction

   function automatic logic [13:0] expv(input int k);
      return {m_vo[k], m_z0[k], m_pktv[k], m_pktz[k], m_serr[k], m_err[k], m_zl[k], m_lerr[k]};
   endfunction

   task automatic model_reset();
      m_in_pkt = 1'b0;
      m_ones   = 0;
      for (int k = 0; k < 2; k++) begin
         m_vo[k] = 1'b0; m_z0[k] = 1'b0; m_pktv[k] = 1'b0; m_pktz[k] = 1'b0;
         m_serr[k] = 1'b0; m_err[k] = 1'b0; m_zl[k] = 4'h0; m_lerr[k] = 4'h0;
      end
   endtask

   // Packet parity is the parity of the total number of ones seen since SOP.
   task automatic model_step();
      bit   serr_e, pkt_e, pkt_par;
      int   ones;
      logic ob;
      logic [3:0] lp;
      if (!CE) return;
      serr_e = 1'b0; pkt_e = 1'b0; pkt_par = 1'b0;
      ones = $countones(D);
      if (VI) begin
         if (SOP) begin
            serr_e   = m_in_pkt;
            m_ones   = ones;
            m_in_pkt = 1'b1;
         end else if (m_in_pkt) begin
            m_ones = m_ones + ones;
         end else begin
            serr_e = 1'b1;
         end
         if (EOP && m_in_pkt) begin
            pkt_e    = 1'b1;
            pkt_par  = (m_ones % 2) == 1;
            m_in_pkt = 1'b0;
         end
      end
      for (int k = 0; k < 2; k++) begin
         ob = (k == 1);
         m_vo[k]   = VI;
         m_lerr[k] = 4'h0;
         m_pktv[k] = pkt_e;
         m_serr[k] = serr_e;
         if (pkt_e) m_pktz[k] = pkt_par ^ ob;
         if (VI) begin
            for (int i = 0; i < 4; i++) lp[i] = (($countones(D[i*8 +: 8]) % 2) == 1) ^ ob;
            m_zl[k] = lp;
            m_z0[k] = ((ones % 2) == 1) ^ ob;
            if (CHKEN) m_lerr[k] = lp ^ PCHK;
         end
         if ((m_lerr[k] != 4'h0) || serr_e) m_err[k] = 1'b1;
         else if (CLR) m_err[k] = 1'b0;
      end
   endtask

   task automatic beat(input logic ce, input logic vi, input logic sop, input logic eop,
                       input logic [31:0] d, input logic chken, input logic [3:0] pchk,
                       input logic clr);
      CE = ce; VI = vi; SOP = sop; EOP = eop; D = d; CHKEN = chken; PCHK = pchk; CLR = clr;
      model_step();
      @(posedge CK);
      #1;
   endtask

   task automatic idle(input logic clr);
      beat(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, clr);
   endtask

   task automatic do_reset();
      RSTN = 1'b0;
      #2;
      model_reset();
      @(posedge CK);
      #1;
      RSTN = 1'b1;
   endtask

   task automatic test_reset();
      beat(1'b1, 1'b1, 1'b1, 1'b0, 32'h1, 1'b0, 4'h0, 1'b0);
      beat(1'b1, 1'b1, 1'b0, 1'b0, 32'h3, 1'b1, 4'h0, 1'b0);
      RSTN = 1'b0;
      #2;
      for (int k = 0; k < 2; k++) begin
         n_tests++;
         if (obs(k) !== 14'h0) begin
            n_fail++;
            $display("FAIL reset_outputs dut%0d got %h expected %h", k, obs(k), 14'h0);
         end
      end
      model_reset();
      @(posedge CK);
      #1;
      RSTN = 1'b1;
      for (int c = 0; c < 5; c++) begin
         idle(1'b0);
         n_tests++;
         if ({vo[0], pktv[0], vo[1], pktv[1]} !== 4'b0000) begin
            n_fail++;
            $display("FAIL idle_vo_pktv cyc%0d got %b expected 0000", c, {vo[0], pktv[0], vo[1], pktv[1]});
         end
      end
      // The packet cut by reset must not complete: EOP now lands in IDLE.
      beat(1'b1, 1'b1, 1'b0, 1'b1, 32'h3, 1'b0, 4'h0, 1'b0);
      n_tests++;
      if ({serr[0], pktv[0]} !== 2'b10) begin
         n_fail++;
         $display("FAIL reset_discard serr/pktv got %b expected 10", {serr[0], pktv[0]});
      end
      idle(1'b1);
   endtask

   task automatic test_lane_parity();
      beat(1'b1, 1'b1, 1'b1, 1'b1, 32'h0100_0301, 1'b0, 4'h0, 1'b0);
      n_tests++;
      if ({vo[0], zl[0], z0[0]} !== {1'b1, 4'b1001, 1'b0}) begin
         n_fail++;
         $display("FAIL lane_even got vo/zl/z0 %b %b %b expected 1 1001 0", vo[0], zl[0], z0[0]);
      end
      n_tests++;
      if ({vo[1], zl[1], z0[1]} !== {1'b1, 4'b0110, 1'b1}) begin
         n_fail++;
         $display("FAIL lane_odd got vo/zl/z0 %b %b %b expected 1 0110 1", vo[1], zl[1], z0[1]);
      end
      idle(1'b0);
      n_tests++;
      if ({vo[0], zl[0], z0[0]} !== {1'b0, 4'b1001, 1'b0}) begin
         n_fail++;
         $display("FAIL lane_hold got vo/zl/z0 %b %b %b expected 0 1001 0", vo[0], zl[0], z0[0]);
      end
   endtask

   task automatic test_packet();
      beat(1'b1, 1'b1, 1'b1, 1'b0, 32'h1, 1'b0, 4'h0, 1'b0);
      beat(1'b1, 1'b1, 1'b0, 1'b0, 32'h3, 1'b0, 4'h0, 1'b0);
      n_tests++;
      if (pktv[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL pkt_early_pktv got %b expected 0", pktv[0]);
      end
      beat(1'b1, 1'b1, 1'b0, 1'b1, 32'h7, 1'b0, 4'h0, 1'b0);
      n_tests++;
      if ({pktv[0], pktz[0], pktv[1], pktz[1]} !== 4'b1011) begin
         n_fail++;
         $display("FAIL pkt_3beat got %b expected 1011", {pktv[0], pktz[0], pktv[1], pktz[1]});
      end
      idle(1'b0);
      n_tests++;
      if ({pktv[0], pktz[0]} !== 2'b00) begin
         n_fail++;
         $display("FAIL pkt_pulse_hold got %b expected 00", {pktv[0], pktz[0]});
      end
      beat(1'b1, 1'b1, 1'b1, 1'b1, 32'h1, 1'b0, 4'h0, 1'b0);
      n_tests++;
      if ({pktv[0], pktz[0], pktv[1], pktz[1]} !== 4'b1110) begin
         n_fail++;
         $display("FAIL pkt_single got %b expected 1110", {pktv[0], pktz[0], pktv[1], pktz[1]});
      end
   endtask

   task automatic test_framing();
      idle(1'b1);
      n_tests++;
      if (err[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL frame_clr got %b expected 0", err[0]);
      end
      beat(1'b1, 1'b1, 1'b0, 1'b0, 32'h5, 1'b0, 4'h0, 1'b0);
      n_tests++;
      if ({serr[0], err[0], serr[1], err[1]} !== 4'b1111) begin
         n_fail++;
         $display("FAIL frame_nosop got %b expected 1111", {serr[0], err[0], serr[1], err[1]});
      end
      idle(1'b1);
      beat(1'b1, 1'b1, 1'b1, 1'b0, 32'h1, 1'b0, 4'h0, 1'b0);
      beat(1'b1, 1'b1, 1'b1, 1'b0, 32'h3, 1'b0, 4'h0, 1'b0);
      n_tests++;
      if ({serr[0], err[0]} !== 2'b11) begin
         n_fail++;
         $display("FAIL frame_resop got %b expected 11", {serr[0], err[0]});
      end
      beat(1'b1, 1'b1, 1'b0, 1'b1, 32'h7, 1'b0, 4'h0, 1'b0);
      n_tests++;
      if ({serr[0], pktv[0], pktz[0]} !== 3'b011) begin
         n_fail++;
         $display("FAIL frame_restart_pkt got %b expected 011", {serr[0], pktv[0], pktz[0]});
      end
      idle(1'b1);
   endtask

   task automatic test_checker();
      beat(1'b1, 1'b1, 1'b1, 1'b1, 32'h1, 1'b1, 4'b0000, 1'b0);
      n_tests++;
      if ({lerr[0], err[0], lerr[1], err[1]} !== {4'b0001, 1'b1, 4'b1110, 1'b1}) begin
         n_fail++;
         $display("FAIL chk_mismatch got %b expected 0001_1_1110_1", {lerr[0], err[0], lerr[1], err[1]});
      end
      beat(1'b1, 1'b1, 1'b1, 1'b1, 32'h1, 1'b1, 4'b0000, 1'b1);
      n_tests++;
      if (err[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL chk_set_wins got %b expected 1", err[0]);
      end
      idle(1'b1);
      n_tests++;
      if ({lerr[0], err[0]} !== 5'b0) begin
         n_fail++;
         $display("FAIL chk_clear got %b expected 00000", {lerr[0], err[0]});
      end
      beat(1'b1, 1'b1, 1'b1, 1'b1, 32'h1, 1'b1, 4'b0001, 1'b0);
      n_tests++;
      if ({lerr[0], err[0]} !== 5'b0) begin
         n_fail++;
         $display("FAIL chk_match got %b expected 00000", {lerr[0], err[0]});
      end
   endtask

   task automatic test_ce_freeze();
      beat(1'b1, 1'b1, 1'b1, 1'b0, 32'h1, 1'b0, 4'h0, 1'b0);
      for (int c = 0; c < 3; c++) begin
         beat(1'b0, 1'b1, 1'b0, 1'b1, $urandom, 1'b1, 4'h0, 1'b1);
         n_tests++;
         if ({vo[0], zl[0], z0[0], pktv[0], lerr[0]} !== {1'b1, 4'b0001, 1'b1, 1'b0, 4'b0000}) begin
            n_fail++;
            $display("FAIL ce_freeze cyc%0d got %b expected 1_0001_1_0_0000", c,
                     {vo[0], zl[0], z0[0], pktv[0], lerr[0]});
         end
      end
      beat(1'b1, 1'b1, 1'b0, 1'b1, 32'h1, 1'b0, 4'h0, 1'b0);
      n_tests++;
      if ({pktv[0], pktz[0], serr[0]} !== 3'b100) begin
         n_fail++;
         $display("FAIL ce_resume got %b expected 100", {pktv[0], pktz[0], serr[0]});
      end
      beat(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0);
      n_tests++;
      if ({pktv[0], vo[0]} !== 2'b11) begin
         n_fail++;
         $display("FAIL ce_pulse_frozen got %b expected 11", {pktv[0], vo[0]});
      end
      idle(1'b0);
      n_tests++;
      if ({pktv[0], vo[0]} !== 2'b00) begin
         n_fail++;
         $display("FAIL ce_pulse_end got %b expected 00", {pktv[0], vo[0]});
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         beat(($urandom % 8) != 0, ($urandom % 4) != 0, ($urandom % 4) == 0,
              ($urandom % 4) == 0, $urandom, ($urandom % 2) == 0, 4'($urandom),
              ($urandom % 6) == 0);
         for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (obs(k) !== expv(k)) begin
               n_fail++;
               $display("FAIL rand dut%0d cyc%0d got %b expected %b", k, c, obs(k), expv(k));
            end
         end
      end
   endtask

   initial begin
      RSTN = 1'b0; CE = 1'b0; VI = 1'b0; SOP = 1'b0; EOP = 1'b0;
      D = 32'h0; CHKEN = 1'b0; PCHK = 4'h0; CLR = 1'b0;
      model_reset();
      repeat (2) @(posedge CK);
      #1;
      RSTN = 1'b1;
      test_reset();
      test_lane_parity();
      test_packet();
      test_framing();
      test_checker();
      test_ce_freeze();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
